// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - registered instruction-decode stage with elastic output queue
//
// Purpose: classifies 16-bit instructions (R, I, special, shift, Bcond),
// extends immediates to IMM_WIDTH, flags illegal encodings and buffers the
// decoded results in a DEPTH-entry circular queue drained by the consumer.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   flush               synchronous queue clear, beats every other action
//   in_valid/in_ready   fetch-side handshake, instruction[15:0] payload
//   out_valid/out_ready consumer-side handshake on the head entry
//   instructionOp, regAddA, regAddB, immediate, flagOp, illegal
//                       decoded head entry, all zero while the queue is empty
//   count               queue occupancy
//   illegal_cnt         saturating count of illegal instructions enqueued
module decode_queue #(
  parameter int DEPTH     = 4,
  parameter int IMM_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             instructionOp,
  output logic [3:0]             regAddA,
  output logic [3:0]             regAddB,
  output logic [IMM_WIDTH-1:0]   immediate,
  output logic [3:0]             flagOp,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  typedef struct packed {
    logic [7:0]           op;
    logic [3:0]           a;
    logic [3:0]           b;
    logic [IMM_WIDTH-1:0] imm;
    logic [3:0]           flag;
    logic                 ill;
  } entry_t;

  logic [3:0] w_op;
  logic [3:0] w_rd;
  logic [3:0] w_ext;
  logic [3:0] w_rs;
  logic       w_ill;
  entry_t     w_dec;
  entry_t     w_head;
  logic       w_enq;
  logic       w_deq;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_illegal_cnt;

  assign w_op  = instruction[15:12];
  assign w_rd  = instruction[11:8];
  assign w_ext = instruction[7:4];
  assign w_rs  = instruction[3:0];

  // Combinational decode of the incoming instruction.
  always_comb begin
    w_dec = '0;
    w_ill = 1'b0;
    if (w_op == 4'b0000) begin
      w_dec.op = {w_op, w_ext};
      w_dec.a  = w_rs;
      w_dec.b  = w_rd;
    end else if (w_op[1:0] != 2'b00) begin
      w_dec.op = {w_op, 4'h0};
      w_dec.b  = w_rd;
      // Only the three lowest I-form opcodes take an unsigned immediate.
      if (w_op[3:2] == 2'b00)
        w_dec.imm = IMM_WIDTH'(instruction[7:0]);
      else
        w_dec.imm = IMM_WIDTH'($signed(instruction[7:0]));
    end else if (w_op == 4'b0100) begin
      w_dec.op = {w_op, w_ext};
      case (w_ext)
        4'b0000, 4'b0100: begin
          w_dec.a = w_rs;
          w_dec.b = w_rd;
        end
        4'b1000: begin
          w_dec.a    = w_rs;
          w_dec.b    = w_rd;
          w_dec.flag = 4'hF;
        end
        4'b1100: begin
          w_dec.a    = w_rs;
          w_dec.flag = w_rd;
        end
        default: w_ill = 1'b1;
      endcase
    end else if (w_op == 4'b1000) begin
      w_dec.op = {w_op, w_ext};
      if (w_ext == 4'b0100) begin
        w_dec.a = w_rs;
        w_dec.b = w_rd;
      end else if (w_ext[3:1] == 3'b000) begin
        // LSHI: 5-bit signed shift amount lives in instruction[4:0].
        w_dec.b   = w_rd;
        w_dec.imm = IMM_WIDTH'($signed(instruction[4:0]));
      end else begin
        w_ill = 1'b1;
      end
    end else begin
      w_dec.op   = {w_op, 4'h0};
      w_dec.flag = w_rd;
      w_dec.imm  = IMM_WIDTH'($signed(instruction[7:0]));
    end
    if (w_ill) begin
      w_dec     = '0;
      w_dec.op  = 8'hFF;
      w_dec.ill = 1'b1;
    end
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != '0);
  assign w_enq     = in_valid && in_ready && !flush;
  assign w_deq     = out_valid && out_ready && !flush;

  // Storage is not reset or scrubbed; out_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (w_enq)
      r_mem[r_wr_ptr] <= w_dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_deq)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Survives flush; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_illegal_cnt <= '0;
    else if (w_enq && w_dec.ill && (r_illegal_cnt != 8'hFF))
      r_illegal_cnt <= r_illegal_cnt + 8'd1;
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    instructionOp = '0;
    regAddA       = '0;
    regAddB       = '0;
    immediate     = '0;
    flagOp        = '0;
    illegal       = 1'b0;
    if (out_valid) begin
      instructionOp = w_head.op;
      regAddA       = w_head.a;
      regAddB       = w_head.b;
      immediate     = w_head.imm;
      flagOp        = w_head.flag;
      illegal       = w_head.ill;
    end
  end

  assign count       = r_count;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized self-checking bench for decode_queue
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int IMMW  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     instruction;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      instructionOp;
  logic [3:0]      regAddA;
  logic [3:0]      regAddB;
  logic [IMMW-1:0] immediate;
  logic [3:0]      flagOp;
  logic            illegal;
  logic [CW-1:0]   count;
  logic [7:0]      illegal_cnt;

  decode_queue #(.DEPTH(DEPTH), .IMM_WIDTH(IMMW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instruction   (instruction),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .instructionOp (instructionOp),
    .regAddA       (regAddA),
    .regAddB       (regAddB),
    .immediate     (immediate),
    .flagOp        (flagOp),
    .illegal       (illegal),
    .count         (count),
    .illegal_cnt   (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      op;
    logic [3:0]      a;
    logic [3:0]      b;
    logic [3:0]      f;
    logic [IMMW-1:0] imm;
    logic            ill;
  } dec_t;

  dec_t mq[$];
  int   ill_cnt;
  int   checks;
  int   failures;
  int   saved_ill;

  function automatic dec_t ref_decode(input logic [15:0] i);
    dec_t d;
    int op, rd, ext, rs, s8, s5;
    op  = int'(i[15:12]);
    rd  = int'(i[11:8]);
    ext = int'(i[7:4]);
    rs  = int'(i[3:0]);
    s8  = int'(i[7:0]);
    if (s8 >= 128) s8 = s8 - 256;
    s5  = int'(i[4:0]);
    if (s5 >= 16) s5 = s5 - 32;
    d.op = 0; d.a = 0; d.b = 0; d.f = 0; d.imm = 0; d.ill = 0;
    if (op == 0) begin
      d.op = 8'(ext);
      d.a  = 4'(rs);
      d.b  = 4'(rd);
    end else if (op % 4 != 0) begin
      d.op = 8'(op * 16);
      d.b  = 4'(rd);
      if (op <= 3) d.imm = IMMW'(int'(i[7:0]));
      else         d.imm = IMMW'(s8);
    end else if (op == 4) begin
      d.op = 8'(64 + ext);
      if (ext == 0 || ext == 4) begin
        d.a = 4'(rs); d.b = 4'(rd);
      end else if (ext == 8) begin
        d.a = 4'(rs); d.b = 4'(rd); d.f = 4'd15;
      end else if (ext == 12) begin
        d.a = 4'(rs); d.f = 4'(rd);
      end else begin
        d.ill = 1;
      end
    end else if (op == 8) begin
      d.op = 8'(128 + ext);
      if (ext == 4) begin
        d.a = 4'(rs); d.b = 4'(rd);
      end else if (ext < 2) begin
        d.b = 4'(rd); d.imm = IMMW'(s5);
      end else begin
        d.ill = 1;
      end
    end else begin
      d.op  = 8'hC0;
      d.f   = 4'(rd);
      d.imm = IMMW'(s8);
    end
    if (d.ill) begin
      d.op = 8'hFF; d.a = 0; d.b = 0; d.f = 0; d.imm = 0;
    end
    return d;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       v[15:12] = 4'h4;
      1:       v[15:12] = 4'h8;
      default: ;
    endcase
    if (v[15:12] == 4'h4 && $urandom_range(0, 1) == 1)
      v[7:4] = {v[7:6], 2'b00};
    if (v[15:12] == 4'h8 && $urandom_range(0, 1) == 1)
      v[7:4] = ($urandom_range(0, 1) == 1) ? 4'h4 : {3'b000, v[4]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    dec_t h;
    int   n;
    n = mq.size();
    h.op = 0; h.a = 0; h.b = 0; h.f = 0; h.imm = 0; h.ill = 0;
    if (n > 0) h = mq[0];
    chk({tag, ".count"},       32'(count),         32'(n));
    chk({tag, ".in_ready"},    32'(in_ready),      32'(n < DEPTH));
    chk({tag, ".out_valid"},   32'(out_valid),     32'(n > 0));
    chk({tag, ".illegal_cnt"}, 32'(illegal_cnt),   32'(ill_cnt));
    chk({tag, ".op"},          32'(instructionOp), 32'(h.op));
    chk({tag, ".regA"},        32'(regAddA),       32'(h.a));
    chk({tag, ".regB"},        32'(regAddB),       32'(h.b));
    chk({tag, ".imm"},         32'(immediate),     32'(h.imm));
    chk({tag, ".flag"},        32'(flagOp),        32'(h.f));
    chk({tag, ".illegal"},     32'(illegal),       32'(h.ill));
  endtask

  // One clock: model follows the handshake rules at the edge, outputs checked at negedge.
  task automatic tick(input string tag);
    bit   enq, deq;
    dec_t d;
    @(posedge clk);
    if (!reset) begin
      if (flush) begin
        mq.delete();
      end else begin
        enq = in_valid && (mq.size() < DEPTH);
        deq = (mq.size() > 0) && out_ready;
        if (deq) void'(mq.pop_front());
        if (enq) begin
          d = ref_decode(instruction);
          mq.push_back(d);
          if (d.ill && ill_cnt < 255) ill_cnt++;
        end
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins, input logic ordy, input logic fl);
    in_valid    = iv;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
  endtask

  initial begin
    checks = 0; failures = 0; ill_cnt = 0;
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset.in_ready_hi", 32'(in_ready), 32'd1);
    reset = 1'b0;

    drive(1'b1, 16'h0A53, 1'b1, 1'b0);
    tick("r_form");
    chk("r_form.op_const",  32'(instructionOp), 32'h05);
    chk("r_form.a_const",   32'(regAddA),       32'h3);
    chk("r_form.b_const",   32'(regAddB),       32'hA);

    drive(1'b1, 16'h15F0, 1'b1, 1'b0);
    tick("i_zext");
    chk("i_zext.imm_const", 32'(immediate), 32'h00F0);

    drive(1'b1, 16'h55F0, 1'b1, 1'b0);
    tick("i_sext");
    chk("i_sext.imm_const", 32'(immediate), 32'hFFF0);

    drive(1'b1, 16'hC780, 1'b1, 1'b0);
    tick("bcond");
    chk("bcond.op_const",   32'(instructionOp), 32'hC0);
    chk("bcond.flag_const", 32'(flagOp),        32'h7);
    chk("bcond.imm_const",  32'(immediate),     32'hFF80);

    drive(1'b1, 16'h4020, 1'b1, 1'b0);
    tick("illegal");
    chk("illegal.flag_const", 32'(illegal),       32'd1);
    chk("illegal.op_const",   32'(instructionOp), 32'hFF);
    chk("illegal.cnt_const",  32'(illegal_cnt),   32'd1);

    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick("drain0");

    for (int k = 0; k < 5; k++) begin
      drive(1'b1, rand_instr(), 1'b0, 1'b0);
      tick("fill");
    end
    chk("fill.count_const", 32'(count),    32'(DEPTH));
    chk("fill.ready_low",   32'(in_ready), 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick("drain");
      end
      for (int k = 0; k < DEPTH - 1; k++) begin
        drive(1'b1, rand_instr(), 1'b0, 1'b0);
        tick("refill");
      end
    end

    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    tick("top_up");
    chk("top_up.full", 32'(count), 32'(DEPTH));
    drive(1'b1, rand_instr(), 1'b1, 1'b0);
    tick("full_pop");
    chk("full_pop.count",    32'(count),    32'(DEPTH - 1));
    chk("full_pop.ready_hi", 32'(in_ready), 32'd1);

    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick("to_two");
    chk("to_two.count", 32'(count), 32'd2);
    drive(1'b1, rand_instr(), 1'b1, 1'b0);
    tick("push_pop");
    chk("push_pop.count", 32'(count), 32'd2);

    drive(1'b1, 16'h4030, 1'b0, 1'b0);
    tick("to_three");
    chk("to_three.count", 32'(count), 32'd3);
    saved_ill = int'(illegal_cnt);
    drive(1'b1, 16'h4050, 1'b0, 1'b1);
    tick("flush");
    chk("flush.count",     32'(count),       32'd0);
    chk("flush.out_valid", 32'(out_valid),   32'd0);
    chk("flush.ill_hold",  32'(illegal_cnt), 32'(saved_ill));

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, rand_instr(), 1'b0, 1'b0);
      tick("pre_reset");
    end
    #2 reset = 1'b1;
    #1;
    mq.delete();
    ill_cnt = 0;
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 16'h0A53, 1'b0, 1'b0);
    tick("post_reset");
    chk("post_reset.count", 32'(count), 32'd1);

    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
      tick("random");
    end

    for (int k = 0; k < 300; k++) begin
      drive(1'b1, {4'h4, 4'($urandom), 4'h2, 4'($urandom)}, 1'b1, 1'b0);
      tick("saturate");
    end
    chk("saturate.cnt_const", 32'(illegal_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
